mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file and consumes its registered read-data outputs (RD1 → rs1, RD2 → rs2) in the execute stage.
- Supports MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Uses a one-bit-per-cycle shift-add multiplier and a one-bit-per-cycle restoring divider. Control is start/busy/done.
- Results go to the writeback mux and from there to the register file write port.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- res  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  32  operand A (register file RD1)
- rs2  input  32  operand B (register file RD2)
- flush  input  1  synchronous abort (pipeline flush)
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse; result valid
- result  output  32  result; holds value until next done

Behaviour:
- Reset: the clock and reset are one clock and an asynchronous, active-high reset, named clk and res.
  - res high immediately forces state IDLE and busy=0, done=0, result=0.
  - Also clears the internal accumulator, quotient, remainder, counter and sign flags.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge T latches op, both operand magnitudes and the result-sign flags.
  - Normally moves to CALC with count=0.
  - Fast path goes to DONE instead (divide ops only):
    - rs2==0: quotient=0xFFFFFFFF, remainder=rs1 (all four div ops).
    - DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Fast path: done=1 during cycle after edge T.
- CALC:
  - Executes one iteration per cycle for exactly 32 cycles (count 0..31).
  - On count==31 moves to DONE.
  - Normal op: done=1 in the cycle after edge T+32.
  - Accept-to-done latency is 33 cycles.
- DONE:
  - Applies sign correction and registers result.
  - done=1 for one cycle, then returns to IDLE.
  - A new start may be accepted on the first IDLE cycle; back-to-back throughput is 34 cycles/op.
- start while busy=1 is ignored; the issuing stage must stall on busy.
- flush: in CALC, flush=1 forces IDLE next edge, result unchanged, no done. In IDLE or DONE flush has no effect (a pending DONE still completes).
- Simultaneous start and flush in IDLE: flush wins, request dropped.
- Multiply:
  - Operands are converted to magnitudes. rs1 is signed for MULH and MULHSU; rs2 is signed for MULH only.
  - 64-bit unsigned product accumulates by shift-add over 32 cycles.
  - Final product is negated (two's complement, 64-bit) if exactly one signed operand was negative.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - Signed ops (DIV, REM) use magnitudes.
  - Restoring algorithm with a 33-bit partial remainder, one quotient bit per cycle, MSB first.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Truncation is toward zero.
- Magnitude of 0x80000000 is 0x80000000 unsigned; no overflow in internal 33/64-bit paths.
- Operand inputs are don't-care except at the accepting edge.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) → done 33 cycles after accept, result=0xFFFFFFEB. MULHU of the same operands → 0x00000006.
- MULH rs1=0x80000000, rs2=0x80000000 → result=0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Division by zero: DIVU 100/0 → 0xFFFFFFFF and REM 100/0 → 100, each with done one cycle after accept. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Handshake: pulse start while busy (count 10) → ignored. flush at count 5 → IDLE, no done, result keeps the previous value. start one cycle after done → accepted.
- Assert res asynchronously (between edges) mid-CALC → busy, done and result go to 0 immediately. Release res, issue MUL 3*4 → 12.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle between the execute stage and the
// iterative RV32M multiply/divide unit.
//   start  : request, sampled only while the unit is idle
//   op     : RV32M funct3 selecting MUL..REMU
//   rs1    : operand A (register file RD1)
//   rs2    : operand B (register file RD2)
//   flush  : pipeline flush, aborts an operation in progress
//   busy   : unit is working or presenting a result
//   done   : one-cycle pulse, result valid
//   result : last completed result, held until the next done
// The issuing stage uses the master modport, the unit uses the slave modport.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide execution unit.
// One-bit-per-cycle shift-add multiplier and restoring divider working on
// operand magnitudes; the sign is reapplied when the result is registered.
// Ports:
//   clk : clock, all state updates on the rising edge
//   res : asynchronous active-high reset
//   bus : mul_div_unit_if slave (start/op/rs1/rs2/flush in, busy/done/result out)
// Timing: a normal operation raises done 33 cycles after the accepting edge;
// division by zero and signed overflow take a fast path with done in the
// cycle right after acceptance.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           res,
  mul_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {partial product, multiplier}; div: low half = dividend/quotient
  logic [XLEN-1:0]     rem_q, rem_d;     // restored partial remainder
  logic [XLEN-1:0]     b_q, b_d;         // multiplicand or divisor magnitude
  logic [XLEN-1:0]     result_q, result_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;         // negate product / quotient
  logic                neg_rem_q, neg_rem_d; // negate remainder

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   a_sgn, b_sgn, a_neg, b_neg;
  logic                   div_zero, div_ovf;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_trial, div_diff;
  logic                div_ge;
  logic [XLEN-1:0]     quo_next, rem_next;

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] x,
                                          input logic is_signed);
    // -INT_MIN wraps back to INT_MIN, which is the correct unsigned magnitude
    if (is_signed && (x < 0)) return -x;
    return x;
  endfunction

  function automatic logic [XLEN-1:0] finalize(input logic [2:0]        op,
                                               input logic [2*XLEN-1:0] acc,
                                               input logic [XLEN-1:0]   rem,
                                               input logic              neg,
                                               input logic              neg_rem);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rmd;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd  = neg_rem ? -rem : rem;
    case (op)
      OP_MUL:    return prod[XLEN-1:0];
      OP_MULH:   return prod[2*XLEN-1:XLEN];
      OP_MULHSU: return prod[2*XLEN-1:XLEN];
      OP_MULHU:  return prod[2*XLEN-1:XLEN];
      OP_DIV:    return quo;
      OP_DIVU:   return quo;
      OP_REM:    return rmd;
      OP_REMU:   return rmd;
      default:   return rmd;
    endcase
  endfunction

  assign rs1_s = bus.rs1;
  assign rs2_s = bus.rs2;

  // Operand signedness: divides are signed unless funct3[0] is set;
  // MULHSU treats only rs1 as signed.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    if (bus.op[2]) begin
      a_sgn = ~bus.op[0];
      b_sgn = ~bus.op[0];
    end else begin
      a_sgn = (bus.op == OP_MULH) || (bus.op == OP_MULHSU);
      b_sgn = (bus.op == OP_MULH);
    end
  end

  assign a_neg    = a_sgn && (rs1_s < 0);
  assign b_neg    = b_sgn && (rs2_s < 0);
  assign div_zero = (bus.rs2 == '0);
  assign div_ovf  = ~bus.op[0] && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);

  // Multiply step: conditionally add the multiplicand to the upper half,
  // then shift the whole accumulator right, carry included.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide step: shift in the next dividend bit MSB first and keep
  // the difference only when it did not go negative.
  assign div_trial = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_trial - {1'b0, b_q};
  assign div_ge    = ~div_diff[XLEN];
  assign rem_next  = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
  assign quo_next  = {acc_q[XLEN-2:0], div_ge};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.start) begin
          op_d      = bus.op;
          cnt_d     = '0;
          rem_d     = '0;
          acc_d     = {{XLEN{1'b0}}, mag(rs1_s, a_sgn)};
          b_d       = mag(rs2_s, b_sgn);
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          state_d   = CALC;
          if (bus.op[2] && div_zero) begin
            acc_d     = {{XLEN{1'b0}}, {XLEN{1'b1}}};
            rem_d     = bus.rs1;
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            result_d  = bus.op[1] ? bus.rs1 : {XLEN{1'b1}};
            state_d   = DONE;
          end else if (bus.op[2] && div_ovf) begin
            acc_d     = {{XLEN{1'b0}}, INT_MIN};
            rem_d     = '0;
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            result_d  = bus.op[1] ? '0 : INT_MIN;
            state_d   = DONE;
          end
        end
      end

      CALC: begin
        if (op_q[2]) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], quo_next};
          rem_d = rem_next;
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q + 1'b1;
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Sign correction is folded into the final iteration so the
          // result register is valid for the whole done cycle.
          result_d = finalize(op_q, acc_d, rem_d, neg_q, neg_rem_q);
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: self-checking bench for mul_div_unit. Directed vectors,
// randomized operations against an arithmetic reference model, handshake
// (busy, flush, back-to-back) and asynchronous reset scenarios.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk = 1'b0;
  logic res;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [5:0]  lat;
  } vec_t;

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (o)
      OP_MUL:    p = ua * ub;
      OP_MULH:   p = sa * sb;
      OP_MULHSU: p = sa * ub;
      OP_MULHU:  p = ua * ub;
      OP_DIV: begin
        if (b == 32'd0) p = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h8000_0000;
        else p = sa / sb;
      end
      OP_DIVU:   p = (b == 32'd0) ? '1 : ua / ub;
      OP_REM: begin
        if (b == 32'd0) p = ua;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0;
        else p = sa % sb;
      end
      default:   p = (b == 32'd0) ? ua : ua % ub;
    endcase
    if (o == OP_MULH || o == OP_MULHSU || o == OP_MULHU) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int ref_latency(input logic [2:0] o,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (o[2] && (b == 32'd0)) return 1;
    if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    int unsigned k;
    k = $urandom_range(0, 7);
    case (k)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one request starting at a negedge while idle; returns the observed
  // result, cycles from acceptance to done (-1 on timeout), busy in the first
  // cycle after acceptance, and whether the cycle after done was clean
  // (done low, busy low, result held). Ends on a negedge in idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat,
                        output logic busy0, output logic post_ok);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs1   = a;
    bus.rs2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.rs1   = $urandom;
    bus.rs2   = $urandom;
    busy0     = bus.busy;
    lat       = -1;
    r         = 'x;
    for (int i = 1; i <= 100; i++) begin
      if (bus.done === 1'b1) begin
        lat = i;
        r   = bus.result;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    post_ok = (bus.done === 1'b0) && (bus.busy === 1'b0) && (bus.result === r);
  endtask

  task automatic test_reset();
    res       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.rs1   = '0;
    bus.rs2   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++;
    if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", bus.result); end
    res = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t        v [12];
    logic [31:0] r;
    int          lat;
    logic        b0, pk;
    v[0]  = '{OP_MUL,    32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB, 6'd33};
    v[1]  = '{OP_MULHU,  32'd7,           32'hFFFF_FFFD, 32'h0000_0006, 6'd33};
    v[2]  = '{OP_MULH,   32'h8000_0000,   32'h8000_0000, 32'h4000_0000, 6'd33};
    v[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd33};
    v[4]  = '{OP_DIV,    32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD, 6'd33};
    v[5]  = '{OP_REM,    32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF, 6'd33};
    v[6]  = '{OP_DIVU,   32'd100,         32'd7,         32'd14,        6'd33};
    v[7]  = '{OP_REMU,   32'd100,         32'd7,         32'd2,         6'd33};
    v[8]  = '{OP_DIVU,   32'd100,         32'd0,         32'hFFFF_FFFF, 6'd1};
    v[9]  = '{OP_REM,    32'd100,         32'd0,         32'd100,       6'd1};
    v[10] = '{OP_DIV,    32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 6'd1};
    v[11] = '{OP_REM,    32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         6'd1};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, r, lat, b0, pk);
      checks++;
      if (r !== v[i].exp) begin
        errors++;
        $display("FAIL directed[%0d] op=%0d result got=%h exp=%h", i, v[i].op, r, v[i].exp);
      end
      checks++;
      if (lat !== int'(v[i].lat)) begin
        errors++;
        $display("FAIL directed[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat);
      end
      checks++;
      if (b0 !== 1'b1) begin errors++; $display("FAIL directed[%0d] busy_after_accept got=%b exp=1", i, b0); end
      checks++;
      if (pk !== 1'b1) begin errors++; $display("FAIL directed[%0d] done_pulse_hold got=%b exp=1", i, pk); end
    end
  endtask

  // Each request is issued in the first idle cycle after the previous done.
  task automatic test_back_to_back();
    logic [2:0]  ops [3];
    logic [31:0] as  [3];
    logic [31:0] bs  [3];
    logic [31:0] r;
    int          lat;
    logic        b0, pk;
    ops[0] = OP_MUL;  as[0] = 32'hFFFF_FFFB; bs[0] = 32'd9;
    ops[1] = OP_DIVU; as[1] = 32'd9;         bs[1] = 32'd0;
    ops[2] = OP_REM;  as[2] = 32'hFFFF_FF9C; bs[2] = 32'd7;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, b0, pk);
      checks++;
      if (r !== ref_model(ops[i], as[i], bs[i])) begin
        errors++;
        $display("FAIL b2b[%0d] result got=%h exp=%h", i, r, ref_model(ops[i], as[i], bs[i]));
      end
      checks++;
      if (lat !== ref_latency(ops[i], as[i], bs[i])) begin
        errors++;
        $display("FAIL b2b[%0d] latency got=%0d exp=%0d", i, lat, ref_latency(ops[i], as[i], bs[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, r;
    int          lat;
    logic        b0, pk;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op(o, a, b, r, lat, b0, pk);
      checks++;
      if (r !== ref_model(o, a, b)) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h result got=%h exp=%h", i, o, a, b, r, ref_model(o, a, b));
      end
      checks++;
      if (lat !== ref_latency(o, a, b)) begin
        errors++;
        $display("FAIL random[%0d] op=%0d latency got=%0d exp=%0d", i, o, lat, ref_latency(o, a, b));
      end
      checks++;
      if (pk !== 1'b1) begin errors++; $display("FAIL random[%0d] done_pulse_hold got=%b exp=1", i, pk); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] r;
    int          lat;
    int          extra;
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.rs1   = 32'd123456;
    bus.rs2   = 32'd789;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    // count 10: a fast-path request that must be ignored
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.rs1   = 32'd5;
    bus.rs2   = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    r   = 'x;
    for (int i = 12; i <= 100; i++) begin
      if (bus.done === 1'b1) begin
        lat = i;
        r   = bus.result;
        break;
      end
      @(negedge clk);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL busy_ignore latency got=%0d exp=33", lat); end
    checks++;
    if (r !== 32'd97406784) begin errors++; $display("FAIL busy_ignore result got=%h exp=%h", r, 32'd97406784); end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL busy_ignore extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_flush();
    logic [31:0] r0, r;
    int          lat, seen;
    logic        b0, pk;
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r0, lat, b0, pk);
    checks++;
    if (r0 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL flush_setup result got=%h exp=fffffffe", r0); end
    // flush at count 5
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.rs1   = 32'd1000;
    bus.rs2   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_calc busy got=%b exp=0", bus.busy); end
    seen = 0;
    repeat (40) begin
      if (bus.done === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_calc done_count got=%0d exp=0", seen); end
    checks++;
    if (bus.result !== r0) begin errors++; $display("FAIL flush_calc result got=%h exp=%h", bus.result, r0); end
    // start and flush together in idle: request dropped
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = OP_MUL;
    bus.rs1   = 32'd2;
    bus.rs2   = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle busy got=%b exp=0", bus.busy); end
    seen = 0;
    repeat (40) begin
      if (bus.done === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_idle done_count got=%0d exp=0", seen); end
    checks++;
    if (bus.result !== r0) begin errors++; $display("FAIL flush_idle result got=%h exp=%h", bus.result, r0); end
    run_op(OP_MUL, 32'd5, 32'd6, r, lat, b0, pk);
    checks++;
    if (r !== 32'd30 || lat !== 33) begin
      errors++;
      $display("FAIL flush_recover result got=%h lat=%0d exp=0000001e lat=33", r, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    int          lat;
    logic        b0, pk;
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.rs1   = 32'd3;
    bus.rs2   = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 res = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL async_reset done got=%b exp=0", bus.done); end
    checks++;
    if (bus.result !== 32'd0) begin errors++; $display("FAIL async_reset result got=%h exp=00000000", bus.result); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset held busy=%b done=%b exp=0 0", bus.busy, bus.done);
    end
    res = 1'b0;
    @(negedge clk);
    run_op(OP_MUL, 32'd3, 32'd4, r, lat, b0, pk);
    checks++;
    if (r !== 32'd12) begin errors++; $display("FAIL post_reset_mul result got=%h exp=0000000c", r); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL post_reset_mul latency got=%0d exp=33", lat); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_busy_ignore();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
